// File: rtl/udp_rx_frame_checker.sv
// Receive-side checker for counter frames (0..FRAME_LEN-1) with good/bad counts and a per-window rate.
// Define UDP_RX_BACKPRESSURE_EN to drive din_ready from a 16-bit LFSR and stall the upstream FIFO.
module udp_rx_frame_checker #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FRAME_LEN = 10,
  parameter int unsigned SYS_FREQ  = 125_000_000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic [DATA_W-1:0] din_data,
  input  logic              din_valid,
  input  logic              din_last,
  output logic              din_ready,
  output logic [CNT_W-1:0]  good_frames,
  output logic [CNT_W-1:0]  bad_frames,
  output logic              word_err,
  output logic              len_err,
  output logic [CNT_W-1:0]  rate_frames,
  output logic              stats_valid,
  output logic              link_ok
);

  localparam int unsigned IDX_W = $clog2(FRAME_LEN);
  localparam int unsigned WIN_W = (SYS_FREQ > 1) ? $clog2(SYS_FREQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SYS_FREQ - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             err_flag;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] win_good;

  logic             accept;
  logic             mismatch;
  logic             at_end;
  logic             checking;
  logic             good_inc;
  logic             bad_inc;
  logic [CNT_W-1:0] win_good_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Per-beat decode of the frame outcome
  always_comb begin
    accept        = din_valid && din_ready;
    mismatch      = din_data != DATA_W'(idx);
    at_end        = idx == LAST_IDX;
    checking      = state != DRAIN;
    good_inc      = accept && checking && at_end && din_last && !(err_flag || mismatch);
    bad_inc       = accept && checking &&
                    (din_last ? (!at_end || err_flag || mismatch) : at_end);
    win_good_next = sat_inc(win_good, good_inc);
  end

`ifdef UDP_RX_BACKPRESSURE_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      lfsr      <= 16'hACE1;
      din_ready <= 1'b0;
    end else begin
      lfsr      <= {lfsr[14:0], lfsr_fb};
      din_ready <= lfsr[0];
    end
  end
`else
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) din_ready <= 1'b0;
    else           din_ready <= 1'b1;
  end
`endif

  // Frame FSM, error pulses and running counters
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state       <= IDLE;
      idx         <= '0;
      err_flag    <= 1'b0;
      word_err    <= 1'b0;
      len_err     <= 1'b0;
      good_frames <= '0;
      bad_frames  <= '0;
    end else begin
      word_err    <= 1'b0;
      len_err     <= 1'b0;
      good_frames <= sat_inc(good_frames, good_inc);
      bad_frames  <= sat_inc(bad_frames, bad_inc);
      if (accept) begin
        case (state)
          IDLE, RUN: begin
            if (mismatch && !err_flag) word_err <= 1'b1;
            if (din_last && !at_end) begin
              len_err  <= 1'b1;
              state    <= IDLE;
              idx      <= '0;
              err_flag <= 1'b0;
            end else if (at_end) begin
              idx      <= '0;
              err_flag <= 1'b0;
              if (din_last) begin
                state <= IDLE;
              end else begin
                len_err <= 1'b1;
                state   <= DRAIN;
              end
            end else begin
              idx      <= idx + IDX_W'(1);
              err_flag <= err_flag | mismatch;
              state    <= RUN;
            end
          end
          DRAIN: begin
            if (din_last) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Statistics window: a good frame ending on the wrap cycle lands in the closing window
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      win_cnt     <= '0;
      win_good    <= '0;
      rate_frames <= '0;
      stats_valid <= 1'b0;
      link_ok     <= 1'b0;
    end else begin
      stats_valid <= 1'b0;
      if (win_cnt == WIN_LAST) begin
        win_cnt     <= '0;
        win_good    <= '0;
        rate_frames <= win_good_next;
        link_ok     <= win_good_next != '0;
        stats_valid <= 1'b1;
      end else begin
        win_cnt  <= win_cnt + WIN_W'(1);
        win_good <= win_good_next;
      end
    end
  end

endmodule

// File: tb/tb_udp_rx_frame_checker.sv
// Scoreboard bench for udp_rx_frame_checker: directed frames, expected events queued by hand.
module tb_udp_rx_frame_checker;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 32;

  logic              sys_clk;
  logic              sys_rstn;
  logic [DATA_W-1:0] din_data;
  logic              din_valid;
  logic              din_last;
  logic              din_ready;
  logic [CNT_W-1:0]  good_frames;
  logic [CNT_W-1:0]  bad_frames;
  logic              word_err;
  logic              len_err;
  logic [CNT_W-1:0]  rate_frames;
  logic              stats_valid;
  logic              link_ok;

  udp_rx_frame_checker #(
    .DATA_W(DATA_W), .FRAME_LEN(10), .SYS_FREQ(1000), .CNT_W(CNT_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rstn(sys_rstn),
    .din_data(din_data), .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
    .good_frames(good_frames), .bad_frames(bad_frames),
    .word_err(word_err), .len_err(len_err),
    .rate_frames(rate_frames), .stats_valid(stats_valid), .link_ok(link_ok)
  );

  typedef struct {
    logic        we;
    logic        le;
    int unsigned good;
    int unsigned bad;
  } ev_t;

  typedef struct {
    int unsigned rate;
    logic        link;
  } st_t;

  ev_t exp_q[$];
  st_t st_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc   = 0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    forever begin
      @(posedge sys_clk);
      if (!sys_rstn) cyc = 0;
      else           cyc = cyc + 1;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_ev(input logic we, input logic le, input int unsigned g, input int unsigned b);
    ev_t e;
    e.we = we; e.le = le; e.good = g; e.bad = b;
    exp_q.push_back(e);
  endtask

  task automatic expect_st(input int unsigned rate, input logic link);
    st_t s;
    s.rate = rate; s.link = link;
    st_q.push_back(s);
  endtask

  // Monitor: any pulse or counter change must match the head of the queue
  initial begin
    logic [CNT_W-1:0] pg, pb;
    ev_t e;
    st_t s;
    pg = '0; pb = '0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rstn) begin
        pg = '0; pb = '0;
      end else begin
        if (word_err || len_err || good_frames != pg || bad_frames != pb) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got we=%0b le=%0b good=%0d bad=%0d, want no event",
                     word_err, len_err, good_frames, bad_frames);
          end else begin
            e = exp_q.pop_front();
            if (word_err !== e.we || len_err !== e.le || good_frames !== CNT_W'(e.good) ||
                bad_frames !== CNT_W'(e.bad)) begin
              n_bad++;
              $display("FAIL event: got we=%0b le=%0b good=%0d bad=%0d, want we=%0b le=%0b good=%0d bad=%0d",
                       word_err, len_err, good_frames, bad_frames, e.we, e.le, e.good, e.bad);
            end
          end
        end
        pg = good_frames; pb = bad_frames;
        if (stats_valid) begin
          n_cmp++;
          if (st_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_stats: got rate=%0d link=%0b, want no stats pulse", rate_frames, link_ok);
          end else begin
            s = st_q.pop_front();
            if (rate_frames !== CNT_W'(s.rate) || link_ok !== s.link) begin
              n_bad++;
              $display("FAIL stats: got rate=%0d link=%0b, want rate=%0d link=%0b",
                       rate_frames, link_ok, s.rate, s.link);
            end
          end
          n_cmp++;
          if (cyc % 1000 != 0) begin
            n_bad++;
            $display("FAIL stats_timing: got pulse at cycle %0d, want a multiple of 1000", cyc);
          end
        end
      end
    end
  end

  task automatic do_reset();
    sys_rstn  = 1'b0;
    din_valid = 1'b0;
    din_last  = 1'b0;
    repeat (2) @(negedge sys_clk);
    n_cmp++;
    if ({din_ready, word_err, len_err, stats_valid, link_ok} !== 5'b0 ||
        good_frames !== '0 || bad_frames !== '0 || rate_frames !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got rdy=%0b we=%0b le=%0b sv=%0b lk=%0b good=%0d bad=%0d rate=%0d, want all 0",
               din_ready, word_err, len_err, stats_valid, link_ok, good_frames, bad_frames, rate_frames);
    end
    sys_rstn = 1'b1;
    @(negedge sys_clk);
    n_cmp++;
    if (din_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_after_reset: got %0b, want 1", din_ready);
    end
  endtask

  // One beat, held until accepted
  task automatic beat(input int unsigned d, input logic l);
    int n;
    din_data  = DATA_W'(d);
    din_valid = 1'b1;
    din_last  = l;
    n = 0;
    while (din_ready !== 1'b1 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: got ready=%0b after 200 cycles, want 1", din_ready);
    end
    @(negedge sys_clk);
  endtask

  task automatic send_frame(input int n, input int last_at, input int bi0, input int bv0,
                            input int bi1, input int bv1);
    int unsigned d;
    for (int i = 0; i < n; i++) begin
      d = (i == bi0) ? bv0 : (i == bi1) ? bv1 : i;
      beat(d, i == last_at);
    end
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    sys_rstn  = 1'b0;
    din_data  = '0;
    din_valid = 1'b0;
    din_last  = 1'b0;

    // Three clean back-to-back frames
    do_reset();
    expect_ev(0, 0, 1, 0); expect_ev(0, 0, 2, 0); expect_ev(0, 0, 3, 0);
    for (int f = 0; f < 3; f++) send_frame(10, 9, -1, 0, -1, 0);
    idle(5);

    // Single and double mismatches, and a mismatch on the final beat
    do_reset();
    expect_ev(1, 0, 0, 0); expect_ev(0, 0, 0, 1);
    send_frame(10, 9, 3, 7, -1, 0);
    expect_ev(0, 0, 1, 1);
    send_frame(10, 9, -1, 0, -1, 0);
    expect_ev(1, 0, 1, 1); expect_ev(0, 0, 1, 2);
    send_frame(10, 9, 1, 5, 2, 6);
    expect_ev(1, 0, 1, 3);
    send_frame(10, 9, 9, 99, -1, 0);
    idle(5);

    // Early last, then a clean frame, then a one-beat frame
    do_reset();
    expect_ev(0, 1, 0, 1);
    send_frame(6, 5, -1, 0, -1, 0);
    expect_ev(0, 0, 1, 1);
    send_frame(10, 9, -1, 0, -1, 0);
    expect_ev(0, 1, 1, 2);
    send_frame(1, 0, -1, 0, -1, 0);
    expect_ev(0, 0, 2, 2);
    send_frame(10, 9, -1, 0, -1, 0);
    idle(5);

    // Overlong frame drains to its last beat without a second bad count
    do_reset();
    expect_ev(0, 1, 0, 1);
    send_frame(13, 12, -1, 0, -1, 0);
    expect_ev(0, 0, 1, 1);
    send_frame(10, 9, -1, 0, -1, 0);
    idle(5);

    // Reset in the middle of a frame discards it
    do_reset();
    for (int i = 0; i < 4; i++) beat(i, 1'b0);
    din_data  = DATA_W'(4);
    din_valid = 1'b1;
    do_reset();
    expect_ev(0, 0, 1, 0);
    send_frame(10, 9, -1, 0, -1, 0);
    idle(5);

    // One good frame per 100 cycles for three windows, then silence
    do_reset();
    expect_st(10, 1); expect_st(10, 1); expect_st(10, 1); expect_st(0, 0);
    for (int k = 0; k < 30; k++) begin
      while (cyc < 100 * k + 5) @(negedge sys_clk);
      expect_ev(0, 0, k + 1, 0);
      send_frame(10, 9, -1, 0, -1, 0);
    end
    while (cyc < 4005) @(negedge sys_clk);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events: got %0d outstanding, want 0", exp_q.size());
    end
    n_cmp++;
    if (st_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_stats: got %0d outstanding, want 0", st_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/udp_rx_frame_checker.md
Name: udp_rx_frame_checker

Overview:
- Consumer for the user read stream of `udp_top` (`rd_data`/`rd_valid`/`rd_last`/`rd_ready`). It is the receive-side counterpart of the incrementing-counter frame generator in the top level.
- Accepts frames whose payload is the words 0,1,…,FRAME_LEN-1, with last on the final word.
- Verifies value and length of each frame, counts good and bad frames, and publishes a once-per-second snapshot for LED/ILA/UART status.

Parameters:
- DATA_W, 32, width of the stream data word.
- FRAME_LEN, 10, expected number of beats per frame (≥2).
- SYS_FREQ, 125_000_000, sys_clk cycles per statistics window.
- CNT_W, 32, width of all statistics counters.

Ports:
- sys_clk  in  1  system clock, all logic on the rising edge.
- sys_rstn  in  1  asynchronous, active-low reset.
- din_data  in  DATA_W  stream data from udp_top rd_data.
- din_valid  in  1  stream valid.
- din_last  in  1  stream last, marks the final beat of a frame.
- din_ready  out  1  stream ready, drives udp_top rd_ready.
- good_frames  out  CNT_W  running count of good frames, saturating.
- bad_frames  out  CNT_W  running count of bad frames, saturating.
- word_err  out  1  one-cycle pulse on the first mismatching beat of a frame.
- len_err  out  1  one-cycle pulse when last arrives early, or is missing at beat FRAME_LEN-1.
- rate_frames  out  CNT_W  good frames counted in the previous 1 s window.
- stats_valid  out  1  one-cycle pulse when rate_frames updates.
- link_ok  out  1  high if at least one good frame arrived in the previous window.

Behaviour:
- Beat accepted = din_valid && din_ready. Nothing is evaluated on cycles with no accepted beat.
- Reset values: din_ready=0, all counters and rate_frames=0, word_err=len_err=stats_valid=link_ok=0, state=IDLE, beat index=0, error flag=0.
- din_ready=1 from the first clock after reset release, unless the optional feature is enabled.
- States:
  - IDLE: waiting for the first beat of a frame; expected value 0.
  - RUN: mid-frame; expected value = beat index.
  - DRAIN: after a length error, discard beats until a beat with last.
- Per accepted beat in IDLE/RUN:
  - compare din_data with the zero-extended beat index;
  - a mismatch sets the sticky frame error flag;
  - word_err pulses the cycle after the first mismatch only.
- Last at index < FRAME_LEN-1:
  - pulse len_err;
  - frame is bad;
  - return to IDLE with index 0.
- Index == FRAME_LEN-1 with last:
  - frame ends;
  - good_frames+1 if the error flag is clear, else bad_frames+1;
  - go to IDLE, index 0, flag cleared.
- Index == FRAME_LEN-1 without last:
  - pulse len_err;
  - bad_frames+1;
  - go to DRAIN.
- DRAIN: discard beats; on an accepted beat with last go to IDLE. DRAIN does not count a second bad frame.
- IDLE with last on beat 0 (1-beat frame): same as early last.
- Counters saturate at all-ones and never wrap.
- Window counter:
  - counts 0..SYS_FREQ-1 and wraps to 0 (no off-by-one; window = SYS_FREQ cycles).
  - Per-window good-frame counter increments with good_frames.
- At the wrap cycle:
  - rate_frames <= window count, including a good frame ending that same cycle;
  - link_ok <= (that value != 0);
  - stats_valid pulses one cycle;
  - window count restarts at 0.
- Output latency: error pulses and counters update one cycle after the accepted beat that causes them.
- Reset asserted mid-frame: everything returns to reset values immediately; the partial frame is not counted.

Optional Feature:
- Macro: UDP_RX_BACKPRESSURE_EN.
- Defined:
  - din_ready = bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1) that advances every cycle;
  - on the first cycle after reset, din_ready is still 0;
  - exercises the udp_top read FIFO under stall.
- Undefined: no LFSR is built and din_ready is as described under Behaviour.
- Checking and statistics are identical in both builds.

Test Plan:
- Three back-to-back frames 0..9, valid every cycle, last on 9 -> good_frames=3, bad_frames=0, no error pulses.
- Frame 0,1,2,7,4..9 with last on 9 -> one word_err pulse after the beat with value 7; bad_frames=1; the next clean frame gives good_frames=1.
- Frame 0..5 with last on 5 -> len_err pulse; bad_frames=1; state IDLE; a following 0..9 frame is good.
- Frame 0..12, last on 12 -> len_err after beat 9; DRAIN swallows 10..12; bad_frames=1; the next frame is good.
- SYS_FREQ=1000, one good frame every 100 cycles -> stats_valid every 1000 cycles, rate_frames=10, link_ok=1; stop traffic -> next window rate_frames=0, link_ok=0.
- Assert sys_rstn low at beat 4, release, send 0..9 -> good_frames=1, bad_frames=0. With UDP_RX_BACKPRESSURE_EN, the same frames held valid across stalls -> identical counts.
